// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional rounding of the quotient is enabled by defining DIVISOR_ROUND_EN.
package divisor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned VW_DEF = 8;

  // Iteration counter width for a DW-bit dividend (DW >= 2).
  function automatic int unsigned iter_width(input int unsigned dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/divisor_step.sv
// One restoring shift-subtract step: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divisor_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] den,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] diff;

  // Shifted remainder is one bit wider so the compare cannot overflow.
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, den};
  assign q_bit   = (shifted >= {1'b0, den});
  assign rem_out = VW'(q_bit ? diff : shifted);

endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle unsigned divider, one quotient bit per clock, start/busy/done
// handshake. Define DIVISOR_ROUND_EN to round the quotient to nearest.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          CLKOUTD,
  input  logic          reset,
  input  logic [DW-1:0] count,
  input  logic [VW-1:0] den,
  input  logic          calculate,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned IW = iter_width(DW);

  state_t        state, state_nx;
  logic [DW-1:0] dvd, dvd_nx;
  logic [VW-1:0] den_r, den_nx;
  logic [VW-1:0] rem, rem_nx;
  logic [IW-1:0] iter, iter_nx;
  logic          zero_r, zero_nx;
  logic          busy_nx, done_nx, dz_nx;
  logic [DW-1:0] quo_nx;
  logic [VW-1:0] rem_o_nx;
  logic [VW-1:0] step_rem;
  logic          step_q;
  logic [DW-1:0] q_final;

  divisor_step #(.VW(VW)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[DW-1]),
    .den     (den_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Quotient accumulates in the low bits of dvd as the dividend shifts out.
`ifdef DIVISOR_ROUND_EN
  logic round_up;
  assign round_up = ({rem, 1'b0} >= {1'b0, den_r});
  assign q_final  = (round_up && (dvd != {DW{1'b1}})) ? dvd + DW'(1) : dvd;
`else
  assign q_final  = dvd;
`endif

  always_ff @(posedge CLKOUTD) begin
    if (reset) begin
      state     <= S_IDLE;
      dvd       <= '0;
      den_r     <= '0;
      rem       <= '0;
      iter      <= '0;
      zero_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nx;
      dvd       <= dvd_nx;
      den_r     <= den_nx;
      rem       <= rem_nx;
      iter      <= iter_nx;
      zero_r    <= zero_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      quotient  <= quo_nx;
      remainder <= rem_o_nx;
      div_zero  <= dz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dvd_nx   = dvd;
    den_nx   = den_r;
    rem_nx   = rem;
    iter_nx  = iter;
    zero_nx  = zero_r;
    busy_nx  = busy;
    done_nx  = 1'b0;
    quo_nx   = quotient;
    rem_o_nx = remainder;
    dz_nx    = div_zero;

    unique case (state)
      S_IDLE: begin
        if (calculate) begin
          dvd_nx   = count;
          den_nx   = den;
          rem_nx   = '0;
          iter_nx  = IW'(DW - 1);
          busy_nx  = 1'b1;
          zero_nx  = (den == '0);
          state_nx = (den == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        dvd_nx  = {dvd[DW-2:0], step_q};
        rem_nx  = step_rem;
        iter_nx = iter - IW'(1);
        if (iter == '0) state_nx = S_FIN;
      end
      S_FIN: begin
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        dz_nx    = zero_r;
        state_nx = S_IDLE;
        if (zero_r) begin
          quo_nx   = {DW{1'b1}};
          rem_o_nx = '0;
        end else begin
          quo_nx   = q_final;
          rem_o_nx = rem;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
